// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive/transmit paths: default geometry,
// receiver state encoding and the loopback test patterns.
package i2s_pkg;

    localparam int unsigned DEF_DATA_W       = 24;
    localparam int unsigned DEF_SLOT_BITS    = 32;
    localparam int unsigned DEF_BCLK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        LEFT,
        RIGHT
    } i2s_state_t;

    localparam logic [23:0] TEST_PAT_A = 24'haaa666;
    localparam logic [23:0] TEST_PAT_B = 24'h555999;

endpackage

// File: rtl/i2s_to_pcm_converter_if.sv
// Serial I2S input and PCM write-side output bundle of the I2S receiver.
interface i2s_to_pcm_converter_if
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              audio_en;
    logic              bclk;
    logic              lrclk;
    logic              s_data;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] r_data;
    logic              l_data_en;
    logic              r_data_en;
    logic              locked;
    logic              frame_err;

    modport master (
        output audio_en, bclk, lrclk, s_data,
        input  l_data, r_data, l_data_en, r_data_en, locked, frame_err
    );

    modport slave (
        input  audio_en, bclk, lrclk, s_data,
        output l_data, r_data, l_data_en, r_data_en, locked, frame_err
    );
endinterface

// File: rtl/i2s_in_sync.sv
// Brings bclk/lrclk/s_data into the clk domain and produces registered
// bclk-rise and lrclk-edge strobes plus the data bit sampled with them.
module i2s_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic bclk,
    input  logic lrclk,
    input  logic s_data,
    output logic rise,
    output logic edge_f,
    output logic edge_r,
    output logic data_bit
);
    logic bclk_s1, bclk_s2, bclk_s3;
    logic lrclk_s1, lrclk_s2;
    logic s_data_s1, s_data_s2;
    logic lrclk_prev;
    logic rise_c;

    assign rise_c = bclk_s2 & ~bclk_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_s1    <= 1'b0;
            bclk_s2    <= 1'b0;
            bclk_s3    <= 1'b0;
            lrclk_s1   <= 1'b0;
            lrclk_s2   <= 1'b0;
            s_data_s1  <= 1'b0;
            s_data_s2  <= 1'b0;
            lrclk_prev <= 1'b0;
            rise       <= 1'b0;
            edge_f     <= 1'b0;
            edge_r     <= 1'b0;
            data_bit   <= 1'b0;
        end else begin
            bclk_s1   <= bclk;
            bclk_s2   <= bclk_s1;
            bclk_s3   <= bclk_s2;
            lrclk_s1  <= lrclk;
            lrclk_s2  <= lrclk_s1;
            s_data_s1 <= s_data;
            s_data_s2 <= s_data_s1;
            // lrclk is only meaningful at bclk rises, so track it there
            if (rise_c)
                lrclk_prev <= lrclk_s2;
            rise     <= rise_c;
            edge_f   <= rise_c & lrclk_prev & ~lrclk_s2;
            edge_r   <= rise_c & ~lrclk_prev & lrclk_s2;
            data_bit <= s_data_s2;
        end
    end
endmodule

// File: rtl/i2s_to_pcm_converter.sv
// I2S receiver: tracks the L/R slot structure of an oversampled I2S stream and
// emits 24-bit PCM words with per-channel enables, lock and framing status.
module i2s_to_pcm_converter
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned SLOT_BITS    = DEF_SLOT_BITS,
    parameter int unsigned BCLK_TIMEOUT = DEF_BCLK_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    i2s_to_pcm_converter_if.slave  bus
);
    localparam int unsigned TW       = $clog2(BCLK_TIMEOUT + 1);
    localparam logic [5:0]  SLOT_DW  = 6'(DATA_W);
    localparam logic [5:0]  SLOT_MAX = 6'(SLOT_BITS);
    localparam logic [TW-1:0] TMO    = TW'(BCLK_TIMEOUT);

    i2s_state_t        state, state_n;
    logic [5:0]        slot, slot_n, slot_inc;
    logic [DATA_W-1:0] shift, shift_n;
    logic [TW-1:0]     tcnt;
    logic              cap_l, cap_r, cap_l_n, cap_r_n;
    logic              ferr_n, lock_clr;
    logic              rise, edge_f, edge_r, data_bit;
    logic              timeout, hs_edge;
    logic [DATA_W-1:0] l_data_q, r_data_q;
    logic              l_en_q, r_en_q, locked_q, ferr_q;

    i2s_in_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .bclk     (bus.bclk),
        .lrclk    (bus.lrclk),
        .s_data   (bus.s_data),
        .rise     (rise),
        .edge_f   (edge_f),
        .edge_r   (edge_r),
        .data_bit (data_bit)
    );

    assign timeout  = (tcnt == TMO);
    assign slot_inc = (slot == 6'd63) ? slot : slot + 6'd1;
    assign hs_edge  = ((state == LEFT) && edge_r) || ((state == RIGHT) && edge_f);

    always_comb begin
        state_n  = state;
        slot_n   = slot;
        shift_n  = shift;
        cap_l_n  = 1'b0;
        cap_r_n  = 1'b0;
        ferr_n   = 1'b0;
        lock_clr = 1'b0;
        // priority: disable, then timeout, then per-rise framing/data
        if (!bus.audio_en) begin
            state_n  = IDLE;
            slot_n   = '0;
            shift_n  = '0;
            lock_clr = 1'b1;
        end else if (state == IDLE) begin
            state_n = SEEK;
        end else if (timeout) begin
            state_n  = SEEK;
            slot_n   = '0;
            shift_n  = '0;
            lock_clr = 1'b1;
        end else if (rise) begin
            slot_n = (edge_f || edge_r) ? 6'd0 : slot_inc;
            case (state)
                SEEK: begin
                    if (edge_f) begin
                        state_n = LEFT;
                        shift_n = '0;
                    end
                end
                default: begin
                    if (hs_edge) begin
                        if (slot < SLOT_DW) begin
                            ferr_n   = 1'b1;
                            lock_clr = 1'b1;
                        end
                        state_n = (state == LEFT) ? RIGHT : LEFT;
                        shift_n = '0;
                    end else if (slot_n > SLOT_MAX) begin
                        ferr_n   = 1'b1;
                        lock_clr = 1'b1;
                        state_n  = SEEK;
                        shift_n  = '0;
                    end else if ((slot_n != 6'd0) && (slot_n <= SLOT_DW)) begin
                        shift_n = {shift[DATA_W-2:0], data_bit};
                        if (slot_n == SLOT_DW) begin
                            cap_l_n = (state == LEFT);
                            cap_r_n = (state == RIGHT);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            slot     <= '0;
            shift    <= '0;
            tcnt     <= '0;
            cap_l    <= 1'b0;
            cap_r    <= 1'b0;
            ferr_q   <= 1'b0;
            l_data_q <= '0;
            r_data_q <= '0;
            l_en_q   <= 1'b0;
            r_en_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state  <= state_n;
            slot   <= slot_n;
            shift  <= shift_n;
            cap_l  <= cap_l_n;
            cap_r  <= cap_r_n;
            ferr_q <= ferr_n;
            if (rise)
                tcnt <= '0;
            else if (!timeout)
                tcnt <= tcnt + TW'(1);
            // completed word is published one cycle after capture; a disable
            // arriving in between suppresses it
            l_en_q <= cap_l & bus.audio_en;
            r_en_q <= cap_r & bus.audio_en;
            if (cap_l && bus.audio_en)
                l_data_q <= shift;
            if (cap_r && bus.audio_en)
                r_data_q <= shift;
            if (lock_clr)
                locked_q <= 1'b0;
            else if (cap_r && bus.audio_en)
                locked_q <= 1'b1;
        end
    end

    assign bus.l_data    = l_data_q;
    assign bus.r_data    = r_data_q;
    assign bus.l_data_en = l_en_q;
    assign bus.r_data_en = r_en_q;
    assign bus.locked    = locked_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_i2s_to_pcm_converter.sv
// Directed bench for the I2S receiver: drives bclk = clk/16 I2S frames and
// checks PCM words, enable timing, lock and framing error behaviour.
module tb_i2s_to_pcm_converter;
    import i2s_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2s_to_pcm_converter_if #(.DATA_W(24)) bus ();

    i2s_to_pcm_converter #(
        .DATA_W       (24),
        .SLOT_BITS    (32),
        .BCLK_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int l_cnt = 0, r_cnt = 0, ferr_cnt = 0, both_cnt = 0;
    int l_cyc = 0, r_cyc = 0, rise24_e0 = 0, r_first = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.l_data_en === 1'b1) begin
            l_cnt++;
            l_cyc = cyc;
        end
        if (bus.r_data_en === 1'b1) begin
            r_cnt++;
            r_cyc = cyc;
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.l_data_en === 1'b1 && bus.r_data_en === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bclk period per bit (8 clk low, 8 clk high); bits 1..24 carry the word MSB first
    task automatic send_bits(input logic lr, input logic [23:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            bus.bclk   = 1'b0;
            bus.lrclk  = lr;
            bus.s_data = (i >= 1 && i <= 24) ? w[5'(24 - i)] : 1'b0;
            repeat (8) @(negedge clk);
            bus.bclk = 1'b1;
            if (i == 24) rise24_e0 = cyc + 1;
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic send_pair(input logic [23:0] lw, input logic [23:0] rw);
        send_bits(1'b0, lw, 0, 31);
        send_bits(1'b1, rw, 0, 31);
    endtask

    initial begin
        bus.audio_en = 1'b0;
        bus.bclk     = 1'b0;
        bus.lrclk    = 1'b0;
        bus.s_data   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_l_data",    32'(bus.l_data),    0);
        chk("reset_r_data",    32'(bus.r_data),    0);
        chk("reset_l_en",      32'(bus.l_data_en), 0);
        chk("reset_r_en",      32'(bus.r_data_en), 0);
        chk("reset_locked",    32'(bus.locked),    0);
        chk("reset_frame_err", 32'(bus.frame_err), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.audio_en = 1'b1;

        // Normal stream: a right half first so the left half starts on a falling lrclk edge
        send_bits(1'b1, 24'h000000, 0, 31);
        send_bits(1'b0, 24'h123456, 0, 31);
        #1;
        chk("norm_l_cnt",   32'(l_cnt), 1);
        chk("norm_l_data",  32'(bus.l_data), 'h123456);
        chk("norm_latency", 32'(l_cyc - rise24_e0), 4);
        chk("norm_unlocked_after_left", 32'(bus.locked), 0);
        send_bits(1'b1, 24'hABCDEF, 0, 31);
        #1;
        chk("norm_r_cnt",  32'(r_cnt), 1);
        chk("norm_r_data", 32'(bus.r_data), 'hABCDEF);
        chk("norm_locked", 32'(bus.locked), 1);
        chk("norm_no_ferr", 32'(ferr_cnt), 0);

        // Test pattern on right, two frames, pulses one frame apart
        send_pair(TEST_PAT_B, TEST_PAT_A);
        r_first = r_cyc;
        send_pair(TEST_PAT_B, TEST_PAT_A);
        #1;
        chk("pat_r_data",  32'(bus.r_data), 'haaa666);
        chk("pat_l_data",  32'(bus.l_data), 'h555999);
        chk("pat_spacing", 32'(r_cyc - r_first), 1024);
        chk("pat_r_cnt",   32'(r_cnt), 3);

        // Short left half: 20 data bits, then lrclk rises
        send_bits(1'b0, 24'h0F0F0F, 0, 20);
        send_bits(1'b1, 24'h777777, 0, 0);
        repeat (6) @(negedge clk);
        #1;
        chk("short_ferr",     32'(ferr_cnt), 1);
        chk("short_unlocked", 32'(bus.locked), 0);
        chk("short_no_l_en",  32'(l_cnt), 3);
        send_bits(1'b1, 24'h777777, 1, 31);
        #1;
        chk("short_relock",  32'(bus.locked), 1);
        chk("short_r_data",  32'(bus.r_data), 'h777777);

        // bclk stalls for 100 clk in the middle of a right word
        send_bits(1'b0, 24'h246810, 0, 31);
        send_bits(1'b1, 24'h13579B, 0, 12);
        repeat (100) @(negedge clk);
        #1;
        chk("tmo_unlocked", 32'(bus.locked), 0);
        chk("tmo_no_r_en",  32'(r_cnt), 4);
        send_bits(1'b1, 24'h13579B, 13, 31);
        #1;
        chk("tmo_seek_no_r_en", 32'(r_cnt), 4);
        chk("tmo_no_ferr",      32'(ferr_cnt), 1);
        send_pair(24'hFEDCBA, 24'h010203);
        #1;
        chk("tmo_resume_l", 32'(bus.l_data), 'hFEDCBA);
        chk("tmo_resume_r", 32'(bus.r_data), 'h010203);
        chk("tmo_relock",   32'(bus.locked), 1);

        // audio_en dropped after 10 bits of a left word
        send_bits(1'b0, 24'h111111, 0, 10);
        @(negedge clk);
        bus.audio_en = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("dis_unlocked", 32'(bus.locked), 0);
        bus.audio_en = 1'b1;
        send_bits(1'b0, 24'h111111, 11, 31);
        send_bits(1'b1, 24'h222222, 0, 31);
        #1;
        chk("dis_no_l_en",  32'(l_cnt), 5);
        chk("dis_no_r_en",  32'(r_cnt), 5);
        chk("dis_l_hold",   32'(bus.l_data), 'hFEDCBA);
        chk("dis_still_unlocked", 32'(bus.locked), 0);
        send_pair(24'h333333, 24'h444444);
        #1;
        chk("dis_relock", 32'(bus.locked), 1);
        chk("dis_l_data", 32'(bus.l_data), 'h333333);
        chk("dis_r_data", 32'(bus.r_data), 'h444444);

        // Asynchronous reset in the middle of a left word
        send_bits(1'b0, 24'h5A5A5A, 0, 15);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_l_data",    32'(bus.l_data),    0);
        chk("arst_r_data",    32'(bus.r_data),    0);
        chk("arst_l_en",      32'(bus.l_data_en), 0);
        chk("arst_r_en",      32'(bus.r_data_en), 0);
        chk("arst_locked",    32'(bus.locked),    0);
        chk("arst_frame_err", 32'(bus.frame_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_bits(1'b0, 24'h5A5A5A, 16, 31);
        send_bits(1'b1, 24'h000000, 0, 31);
        #1;
        chk("arst_no_l_en", 32'(l_cnt), 6);
        send_pair(24'hC3C3C3, 24'h3C3C3C);
        #1;
        chk("arst_l_after", 32'(bus.l_data), 'hC3C3C3);
        chk("arst_r_after", 32'(bus.r_data), 'h3C3C3C);
        chk("arst_locked_after", 32'(bus.locked), 1);
        chk("never_both_en", 32'(both_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
